// File: rtl/fluid_pkg.sv
// Shared constants and the frame-writer state type for the fluid simulation datapath.
package fluid_pkg;

  localparam int DENSITY_IN_W = 10;
  localparam int PIX_W        = 8;
  localparam int LANES        = 9;
  localparam int LANE_CNT_W   = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } density_writer_state_t;

endpackage

// File: rtl/density_packer.sv
// Packs nine accepted density samples into byte lanes of one 72-bit BRAM word.
// DENSITY_WRITER_CLAMP_EN selects saturating byte conversion instead of truncation.
module density_packer
  import fluid_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [DENSITY_IN_W-1:0]       sample,
  output logic [LANES-1:0][PIX_W-1:0]   lanes,
  output logic                          full
);

  logic [LANE_CNT_W-1:0] lane_cnt;
  logic [PIX_W-1:0]      pix;

`ifdef DENSITY_WRITER_CLAMP_EN
  // Any bit above the byte range means the sample exceeds 255 and saturates.
  assign pix = (|sample[DENSITY_IN_W-1:PIX_W]) ? '1 : sample[PIX_W-1:0];
`else
  logic unused_high;
  assign unused_high = ^sample[DENSITY_IN_W-1:PIX_W];
  assign pix         = sample[PIX_W-1:0];
`endif

  assign full = accept && (lane_cnt == LANE_CNT_W'(LANES - 1));

  // NOTE: clocked state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      // NOTE: the lane registers are reset because wdata_out must read zero
      // after reset; a plain storage array would normally be left unreset.
      lanes    <= '0;
    end else if (clear) begin
      lane_cnt <= '0;
    end else if (accept) begin
      lane_cnt <= full ? '0 : lane_cnt + 1'b1;
      for (int k = 0; k < LANES; k++) begin
        if (lane_cnt == LANE_CNT_W'(k)) lanes[k] <= pix;
      end
    end
  end

endmodule

// File: rtl/density_writer.sv
// Streams density samples into 72-bit frame BRAM words, one word per nine samples.
// Build option: DENSITY_WRITER_CLAMP_EN (saturating byte conversion, see density_packer).
module density_writer
  import fluid_pkg::*;
#(
  parameter  int BRAM_DEPTH = 31570,
  localparam int BRAM_SIZE  = $clog2(BRAM_DEPTH)
) (
  input  logic                        pixel_clk_in,
  input  logic                        rst_in,
  input  logic                        sof_in,
  input  logic [DENSITY_IN_W-1:0]     density_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [BRAM_SIZE-1:0]        addr_out,
  output logic [LANES-1:0][PIX_W-1:0] wdata_out,
  output logic                        we_out,
  output logic                        frame_done_out
);

  localparam logic [BRAM_SIZE-1:0] LAST_ADDR = BRAM_SIZE'(BRAM_DEPTH - 1);

  density_writer_state_t state, state_next;
  logic [BRAM_SIZE-1:0]  addr_next;
  logic                  accept;
  logic                  full;

  assign ready_out      = (state == FILL);
  assign we_out         = (state == WRITE);
  assign frame_done_out = (state == DONE);

  // A new frame start discards whatever sample is offered alongside it.
  assign accept = valid_in && ready_out && !sof_in;

  density_packer u_packer (
    .clk    (pixel_clk_in),
    .rst    (rst_in),
    .clear  (sof_in),
    .accept (accept),
    .sample (density_in),
    .lanes  (wdata_out),
    .full   (full)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns both signals; a missing
    // assignment on some path would infer a latch.
    state_next = state;
    addr_next  = addr_out;
    case (state)
      IDLE: begin
        if (sof_in) begin
          state_next = FILL;
          addr_next  = '0;
        end
      end
      FILL: begin
        if (sof_in) begin
          addr_next = '0;
        end else if (full) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (sof_in) begin
          state_next = FILL;
          addr_next  = '0;
        end else if (addr_out == LAST_ADDR) begin
          state_next = DONE;
        end else begin
          state_next = FILL;
          addr_next  = addr_out + 1'b1;
        end
      end
      DONE: begin
        state_next = sof_in ? FILL : IDLE;
        addr_next  = '0;
      end
      default: begin
        state_next = IDLE;
        addr_next  = '0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      addr_out <= '0;
    end else begin
      state    <= state_next;
      addr_out <= addr_next;
    end
  end

endmodule

// File: doc/density_writer.md
DENSITY_WRITER -- requirements
Module: density_writer

Interface
REQ-001 SHALL have parameter BRAM_DEPTH, default 31570, meaning the number of 72-bit words in the frame BRAM.
REQ-002 SHALL have localparam BRAM_SIZE = $clog2(BRAM_DEPTH), used as the address width.
REQ-003 SHALL have port pixel_clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sof_in, input, 1 bit: start-of-frame pulse from the simulation core.
REQ-006 SHALL have port density_in, input, 10 bits: unsigned density sample.
REQ-007 SHALL have port valid_in, input, 1 bit: density_in is valid this cycle.
REQ-008 SHALL have port ready_out, output, 1 bit: block accepts a sample this cycle.
REQ-009 SHALL have port addr_out, output, BRAM_SIZE bits: BRAM write address.
REQ-010 SHALL have port wdata_out, output, [8:0][7:0]: packed word; lane k holds the k-th accepted byte.
REQ-011 SHALL have port we_out, output, 1 bit: BRAM write enable, one-cycle pulse.
REQ-012 SHALL have port frame_done_out, output, 1 bit: one-cycle pulse after the last word of a frame is written.

Function
REQ-013 SHALL implement the states IDLE, FILL, WRITE and DONE.
REQ-014 IDLE: ready_out=0; on sof_in=1 -> FILL, with the lane counter and addr_out both cleared to 0.
REQ-015 FILL: ready_out=1; a sample is accepted on a cycle where valid_in and ready_out are both 1, and that sample is stored into lane[lane counter].
REQ-016 Lane counter: counts 0..8. When lane 8 is accepted, the counter clears and the state goes to WRITE on the next cycle.
REQ-017 WRITE: lasts exactly one cycle; we_out=1; ready_out=0; addr_out and wdata_out are stable for that cycle.
REQ-018 Latency: when lane 8 is accepted in cycle N, we_out SHALL be 1 in cycle N+1. Peak throughput is 9 samples per 10 cycles.
REQ-019 After WRITE, when addr_out /= BRAM_DEPTH-1: addr_out increments by 1 and the state returns to FILL.
REQ-020 After WRITE, when addr_out == BRAM_DEPTH-1: the state goes to DONE and addr_out stays at BRAM_DEPTH-1 (no wrap within a frame).
REQ-021 DONE: lasts one cycle; frame_done_out=1; then -> IDLE, and addr_out clears to 0.
REQ-022 sof_in in FILL or WRITE: the partial word is discarded, and any WRITE in progress still completes in that cycle. Next state is FILL with the lane counter and addr_out both 0.
REQ-023 sof_in in DONE: frame_done_out is still pulsed, and the next state is FILL instead of IDLE.
REQ-024 sof_in while ready_out=1: any sample offered in the same cycle is discarded.
REQ-025 valid_in is ignored whenever ready_out=0, and no sample is lost because the source holds it.
REQ-026 Byte conversion with DENSITY_WRITER_CLAMP_EN undefined: the stored byte is density_in[7:0] (truncation).
REQ-027 we_out and frame_done_out SHALL never both be 1 in the same cycle.

Reset
REQ-028 When rst_in=1 at a clock edge, the state SHALL become IDLE.
REQ-029 The same reset SHALL set ready_out=0, we_out=0, frame_done_out=0, addr_out=0, the lane counter to 0, and wdata_out to all zeros.
REQ-030 Reset SHALL override every other input in that cycle, including sof_in and a WRITE in progress (no we_out pulse).

Configuration
REQ-031 SHALL use the macro DENSITY_WRITER_CLAMP_EN.
REQ-032 With DENSITY_WRITER_CLAMP_EN defined: the stored byte is 255 when density_in > 255, and density_in[7:0] otherwise.
REQ-033 With DENSITY_WRITER_CLAMP_EN undefined: truncation per REQ-026; no extra logic is generated.

Structure
REQ-034 SHALL place in shared package fluid_pkg: DENSITY_IN_W=10, PIX_W=8, LANES=9, and the density_writer_state_t enum (IDLE, FILL, WRITE, DONE).
REQ-035 SHALL instantiate one sub-module, density_packer. It holds the lane registers and lane counter, has its own clear input, and raises a full strobe when lane 8 is accepted.
REQ-036 The FSM, address counter and handshake logic SHALL live in density_writer.

Verification
REQ-037 Fill test: BRAM_DEPTH=4; sof, then samples 1..36 with valid_in held at 1. Expect 4 writes, at addr 0..3. The addr 0 word has lanes 1..9. frame_done_out pulses once, one cycle after the addr 3 write; the block then returns to IDLE.
REQ-038 Backpressure test: valid_in held at 1 continuously. Expect ready_out=0 exactly on WRITE cycles, and no sample duplicated or dropped across 90 samples.
REQ-039 Abort test: sof, 5 samples, then sof again, then samples 100..108. Expect one write at addr 0 with lanes 100..108.
REQ-040 Clamp test: samples 300, 255, 256, 7. Expect bytes 255, 255, 255, 7 with the macro defined, and bytes 44, 255, 0, 7 with it undefined.
REQ-041 Reset test: assert rst_in on the cycle that lane 8 is accepted. Expect no we_out pulse, all outputs 0, and state IDLE; a following sof restarts at addr 0.
REQ-042 Idle test: samples arrive with valid_in=1 but no sof. Expect ready_out to stay 0 and no writes.
